i2c_slave_tx_stream: RTL and testbench

//  Slave-side I2C transmitter: serialises a stream of DATA_WIDTH-bit words onto SDA, MSB first.

---
 rtl/i2c_slave_tx_stream_pkg.sv | 16 +
 rtl/i2c_slave_tx_stream_edge_sync.sv | 34 +++
 rtl/i2c_slave_tx_stream.sv | 169 ++++++++++++++++
 tb/tb_i2c_slave_tx_stream.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_tx_stream_pkg.sv
// Shared types and constants for the I2C slave word-stream transmitter.
// Both SDA levels used by the FSM are named here.
package i2c_slave_tx_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK,
    STRETCH,
    DONE
  } state_t;

  localparam logic SDA_RELEASE = 1'b1;
  localparam logic ACK_BIT     = 1'b0;

endpackage

// File: rtl/i2c_slave_tx_stream_edge_sync.sv
// Multi-flop synchroniser for an asynchronous bus line.
// Provides registered rise/fall pulses derived from the line's previous level.
module i2c_slave_tx_stream_edge_sync #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              last;

  assign level = sync[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{INIT}};
      last <= INIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      last <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~last;
      fall <= ~sync[STAGES-1] & last;
    end
  end

endmodule

// File: rtl/i2c_slave_tx_stream.sv
// Slave-side I2C transmitter: shifts a valid/ready word stream onto SDA,
// MSB first, samples master ACK, stretches SCL when starved, aborts on STOP.
module i2c_slave_tx_stream
  import i2c_slave_tx_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   stop,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda,
  output logic                   scl_hold,
  output logic                   finish,
  output logic                   nack,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-2:0] rest;
  logic [BW-1:0]         bit_cnt;
  logic                  ack_bit;

  logic scl_rise, scl_fall, scl_level_unused;
  logic sda_lvl, sda_rise_unused, sda_fall_unused;
  logic abort, ack_ok, latch;

  i2c_slave_tx_stream_edge_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (1'b1)
  ) u_scl_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (scl_in),
    .level(scl_level_unused),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_slave_tx_stream_edge_sync #(
    .STAGES(SYNC_STAGES),
    .INIT  (1'b1)
  ) u_sda_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sda_in),
    .level(sda_lvl),
    .rise (sda_rise_unused),
    .fall (sda_fall_unused)
  );

  // STOP beats every load; DONE is already on its way out.
  assign abort  = stop && state != IDLE && state != DONE;
  assign ack_ok = state == ACK && scl_fall && ack_bit == ACK_BIT;

  always_comb begin
    latch = 1'b0;
    unique case (1'b1)
      state == IDLE:    latch = enable;
      state == STRETCH: latch = ~abort;
      ack_ok:           latch = ~abort;
      default:          latch = 1'b0;
    endcase
    latch = latch & data_valid & rst_n;
  end

  assign data_ready = latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rest       <= '0;
      bit_cnt    <= '0;
      ack_bit    <= ~ACK_BIT;
      sda        <= SDA_RELEASE;
      scl_hold   <= 1'b0;
      finish     <= 1'b0;
      nack       <= 1'b0;
      byte_count <= '0;
    end else begin
      finish <= 1'b0;
      if (abort) begin
        sda      <= SDA_RELEASE;
        scl_hold <= 1'b0;
        nack     <= 1'b0;
        finish   <= 1'b1;
        state    <= DONE;
      end else begin
        case (state)
          IDLE: if (enable) begin
            byte_count <= '0;
            nack       <= 1'b0;
            bit_cnt    <= '0;
            if (data_valid) begin
              rest  <= data_in[DATA_WIDTH-2:0];
              sda   <= data_in[DATA_WIDTH-1];
              state <= SHIFT;
            end else begin
              scl_hold <= 1'b1;
              state    <= STRETCH;
            end
          end
          SHIFT: begin
            scl_hold <= 1'b0;
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == BIT_LAST) begin
                sda     <= SDA_RELEASE;
                ack_bit <= ~ACK_BIT;
                state   <= ACK;
              end else begin
                sda  <= rest[DATA_WIDTH-2];
                rest <= rest << 1;
              end
            end
          end
          ACK: begin
            if (scl_rise) begin
              ack_bit <= sda_lvl;
            end else if (scl_fall) begin
              if (ack_bit == ACK_BIT) begin
                if (byte_count != '1)
                  byte_count <= byte_count + 1'b1;
                bit_cnt <= '0;
                if (data_valid) begin
                  rest  <= data_in[DATA_WIDTH-2:0];
                  sda   <= data_in[DATA_WIDTH-1];
                  state <= SHIFT;
                end else begin
                  scl_hold <= 1'b1;
                  state    <= STRETCH;
                end
              end else begin
                nack   <= 1'b1;
                finish <= 1'b1;
                state  <= DONE;
              end
            end
          end
          // scl_hold stays up one more cycle so SDA settles first
          STRETCH: if (data_valid) begin
            rest    <= data_in[DATA_WIDTH-2:0];
            sda     <= data_in[DATA_WIDTH-1];
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          DONE: begin
            sda      <= SDA_RELEASE;
            scl_hold <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_tx_stream.sv
// Bench for i2c_slave_tx_stream: an I2C master model clocks words out of
// an 8-bit and a 16-bit instance and checks them against a word-level model.
module tb_i2c_slave_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en1, en2, stop;
  logic scl_m, sda_m, scl_line, sda_line;
  logic data_valid;
  logic [15:0] data_in;
  logic dr1, sda1, hold1, fin1, nack1;
  logic [7:0] bc1;
  logic dr2, sda2, hold2, fin2, nack2;
  logic [1:0] bc2;

  int total = 0;
  int bad = 0;
  logic sel = 1'b0;

  logic [15:0] words [8];
  int feed_n = 0;
  int feed_idx = 0;
  logic feed_rst = 1'b0;

  assign data_valid = feed_idx < feed_n;
  assign data_in    = words[feed_idx[2:0]];
  assign scl_line   = scl_m & ~hold1 & ~hold2;
  assign sda_line   = sda_m & sda1 & sda2;

  logic o_sda, o_hold, o_fin, o_nack;
  logic [7:0] o_bc;
  assign o_sda  = sel ? sda2 : sda1;
  assign o_hold = sel ? hold2 : hold1;
  assign o_fin  = sel ? fin2 : fin1;
  assign o_nack = sel ? nack2 : nack1;
  assign o_bc   = sel ? {6'b0, bc2} : bc1;

  i2c_slave_tx_stream #(
    .DATA_WIDTH(8), .COUNT_WIDTH(8), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .stop(stop),
    .data_in(data_in[7:0]), .data_valid(data_valid),
    .data_ready(dr1), .scl_in(scl_line), .sda_in(sda_line),
    .sda(sda1), .scl_hold(hold1), .finish(fin1),
    .nack(nack1), .byte_count(bc1)
  );

  i2c_slave_tx_stream #(
    .DATA_WIDTH(16), .COUNT_WIDTH(2), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .stop(stop),
    .data_in(data_in), .data_valid(data_valid),
    .data_ready(dr2), .scl_in(scl_line), .sda_in(sda_line),
    .sda(sda2), .scl_hold(hold2), .finish(fin2),
    .nack(nack2), .byte_count(bc2)
  );

  // word source: advances once per accepted word
  always @(posedge clk)
    if (feed_rst) feed_idx <= 0;
    else if (dr1 | dr2) feed_idx <= feed_idx + 1;

  int fin_cnt = 0;
  logic fin_nack = 1'b0;
  int dr_bad = 0;
  always @(negedge clk) begin
    if (o_fin) begin
      fin_cnt  <= fin_cnt + 1;
      fin_nack <= o_nack;
    end
    if ((dr1 | dr2) && !data_valid) dr_bad <= dr_bad + 1;
  end

  function automatic int sat(input int n, input int cw);
    int m;
    m = (1 << cw) - 1;
    return (n > m) ? m : n;
  endfunction

  task automatic clock_bit(input logic drv, output logic smp);
    int n;
    sda_m = drv;
    repeat (8) @(negedge clk);
    scl_m = 1'b1;
    n = 0;
    while (!scl_line && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!scl_line) begin
      bad++;
      $display("FAIL scl_release: scl=%b after %0d clk, required 1", scl_line, n);
    end
    repeat (4) @(negedge clk);
    smp = sda_line;
    repeat (4) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic send_word(input int w, input logic ack,
                           output logic [15:0] got);
    logic b;
    got = '0;
    for (int i = 0; i < w; i++) begin
      clock_bit(1'b1, b);
      got = {got[14:0], b};
    end
    clock_bit(!ack, b);
    sda_m = 1'b1;
  endtask

  task automatic start(input logic which);
    @(negedge clk);
    feed_rst = 1'b1;
    @(negedge clk);
    feed_rst = 1'b0;
    sel = which;
    if (which) en2 = 1'b1;
    else en1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    en2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en1 = 0; en2 = 0; stop = 0;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({sda1, hold1, fin1, nack1, dr1, bc1} !== {5'b10000, 8'h00}) begin
      bad++;
      $display("FAIL reset_dut1: got %b/%h required 10000/00",
               {sda1, hold1, fin1, nack1, dr1}, bc1);
    end
    total++;
    if ({sda2, hold2, fin2, nack2, dr2, bc2} !== {5'b10000, 2'b00}) begin
      bad++;
      $display("FAIL reset_dut2: got %b/%h required 10000/0",
               {sda2, hold2, fin2, nack2, dr2}, bc2);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    scl_m = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if ({sda1, hold1, fin1} !== 3'b100) begin
      bad++;
      $display("FAIL idle_after_reset: got %b required 100", {sda1, hold1, fin1});
    end
  endtask

  task automatic test_stream();
    logic [15:0] got;
    int f0;
    words[0] = 16'h13; words[1] = 16'h57;
    words[2] = 16'h9B; words[3] = 16'hDF;
    feed_n = 4;
    f0 = fin_cnt;
    start(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_word(8, k < 3, got);
      total++;
      if (got[7:0] !== words[k][7:0]) begin
        bad++;
        $display("FAIL stream_word%0d: got %h required %h", k, got[7:0], words[k][7:0]);
      end
      repeat (6) @(negedge clk);
      total++;
      if (o_bc !== 8'(sat(k < 3 ? k + 1 : 3, 8))) begin
        bad++;
        $display("FAIL stream_count%0d: got %0d required %0d", k, o_bc, sat(k < 3 ? k + 1 : 3, 8));
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (fin_cnt - f0 !== 1 || fin_nack !== 1'b1 || feed_idx !== 4) begin
      bad++;
      $display("FAIL stream_end: finishes=%0d nack=%b loads=%0d required 1 1 4",
               fin_cnt - f0, fin_nack, feed_idx);
    end
  endtask

  task automatic test_stretch();
    logic [15:0] got;
    int hb;
    words[0] = 16'($urandom_range(0, 255));
    words[1] = 16'($urandom_range(0, 255));
    feed_n = 1;
    start(1'b0);
    send_word(8, 1'b1, got);
    total++;
    if (got[7:0] !== words[0][7:0]) begin
      bad++;
      $display("FAIL stretch_word0: got %h required %h", got[7:0], words[0][7:0]);
    end
    repeat (4) @(negedge clk);
    hb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (o_hold !== 1'b1) hb++;
    end
    total++;
    if (hb !== 0) begin
      bad++;
      $display("FAIL stretch_hold: %0d clk without hold, required 0", hb);
    end
    feed_n = 2;
    @(negedge clk);
    total++;
    if (o_hold !== 1'b1 || o_sda !== words[1][7]) begin
      bad++;
      $display("FAIL stretch_latch: hold=%b sda=%b required 1 %b", o_hold, o_sda, words[1][7]);
    end
    @(negedge clk);
    total++;
    if (o_hold !== 1'b0) begin
      bad++;
      $display("FAIL stretch_release: hold=%b required 0", o_hold);
    end
    send_word(8, 1'b0, got);
    total++;
    if (got[7:0] !== words[1][7:0]) begin
      bad++;
      $display("FAIL stretch_word1: got %h required %h", got[7:0], words[1][7:0]);
    end
    repeat (8) @(negedge clk);
    total++;
    if (o_bc !== 8'd1 || fin_nack !== 1'b1) begin
      bad++;
      $display("FAIL stretch_end: count=%0d nack=%b required 1 1", o_bc, fin_nack);
    end
  endtask

  task automatic test_enable_stall();
    logic [15:0] got;
    feed_n = 0;
    start(1'b0);
    total++;
    if (o_hold !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold: hold=%b required 1", o_hold);
    end
    fork
      send_word(8, 1'b0, got);
      begin
        repeat (20) @(negedge clk);
        words[0] = 16'h00A5;
        feed_n = 1;
      end
    join
    total++;
    if (got[7:0] !== 8'hA5) begin
      bad++;
      $display("FAIL stall_word: got %h required a5", got[7:0]);
    end
    repeat (8) @(negedge clk);
    total++;
    if (o_bc !== 8'd0 || fin_nack !== 1'b1 || feed_idx !== 1) begin
      bad++;
      $display("FAIL stall_end: count=%0d nack=%b loads=%0d required 0 1 1",
               o_bc, fin_nack, feed_idx);
    end
  endtask

  task automatic test_stop();
    logic [15:0] got;
    logic b;
    int f0;
    words[0] = 16'($urandom_range(0, 255));
    words[1] = 16'($urandom_range(0, 255)) & 16'h00F7;
    feed_n = 2;
    f0 = fin_cnt;
    start(1'b0);
    send_word(8, 1'b1, got);
    got = '0;
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, b);
      got = {got[14:0], b};
    end
    total++;
    if (got[3:0] !== words[1][7:4]) begin
      bad++;
      $display("FAIL stop_partial: got %h required %h", got[3:0], words[1][7:4]);
    end
    repeat (6) @(negedge clk);
    total++;
    if (o_sda !== 1'b0) begin
      bad++;
      $display("FAIL stop_pre_sda: sda=%b required 0", o_sda);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if ({o_sda, o_hold, o_fin, o_nack} !== 4'b1010) begin
      bad++;
      $display("FAIL stop_abort: sda/hold/fin/nack=%b required 1010",
               {o_sda, o_hold, o_fin, o_nack});
    end
    repeat (4) @(negedge clk);
    total++;
    if (o_bc !== 8'd1 || fin_cnt - f0 !== 1 || feed_idx !== 2) begin
      bad++;
      $display("FAIL stop_end: count=%0d finishes=%0d loads=%0d required 1 1 2",
               o_bc, fin_cnt - f0, feed_idx);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    words[0] = 16'($urandom_range(0, 255));
    words[1] = 16'($urandom_range(0, 127));
    feed_n = 2;
    start(1'b0);
    send_word(8, 1'b1, got);
    repeat (6) @(negedge clk);
    total++;
    if (o_sda !== 1'b0 || o_bc !== 8'd1) begin
      bad++;
      $display("FAIL rstmid_pre: sda=%b count=%0d required 0 1", o_sda, o_bc);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({sda1, hold1, fin1, nack1, dr1, bc1} !== {5'b10000, 8'h00}) begin
      bad++;
      $display("FAIL rstmid_async: got %b/%h required 10000/00",
               {sda1, hold1, fin1, nack1, dr1}, bc1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wide_saturate();
    logic [15:0] got;
    for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
    feed_n = 6;
    start(1'b1);
    for (int k = 0; k < 6; k++) begin
      send_word(16, k < 5, got);
      total++;
      if (got !== words[k]) begin
        bad++;
        $display("FAIL wide_word%0d: got %h required %h", k, got, words[k]);
      end
      repeat (6) @(negedge clk);
      total++;
      if (o_bc !== 8'(sat(k < 5 ? k + 1 : 5, 2))) begin
        bad++;
        $display("FAIL wide_count%0d: got %0d required %0d", k, o_bc, sat(k < 5 ? k + 1 : 5, 2));
      end
    end
    repeat (4) @(negedge clk);
    total++;
    if (fin_nack !== 1'b1 || feed_idx !== 6) begin
      bad++;
      $display("FAIL wide_end: nack=%b loads=%0d required 1 6", fin_nack, feed_idx);
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    int n, f0;
    for (int it = 0; it < 2; it++) begin
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom_range(0, 255));
      feed_n = n;
      f0 = fin_cnt;
      start(1'b0);
      for (int k = 0; k < n; k++) begin
        send_word(8, k < n - 1, got);
        total++;
        if (got[7:0] !== words[k][7:0]) begin
          bad++;
          $display("FAIL b2b%0d_word%0d: got %h required %h", it, k, got[7:0], words[k][7:0]);
        end
      end
      repeat (8) @(negedge clk);
      total++;
      if (o_bc !== 8'(sat(n - 1, 8)) || fin_cnt - f0 !== 1 || fin_nack !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d_end: count=%0d finishes=%0d nack=%b required %0d 1 1",
                 it, o_bc, fin_cnt - f0, fin_nack, n - 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) words[i] = '0;
    test_reset();
    test_stream();
    test_stretch();
    test_enable_stall();
    test_stop();
    test_reset_mid();
    test_wide_saturate();
    test_back_to_back();
    total++;
    if (dr_bad !== 0) begin
      bad++;
      $display("FAIL ready_without_valid: %0d cycles, required 0", dr_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
